// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcode encodings,
// sequencer state encoding and the settle-counter width.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHLA = 3'b100;
  localparam logic [2:0] OP_SHRA = 3'b101;
  localparam logic [2:0] OP_SHLB = 3'b110;
  localparam logic [2:0] OP_SHRB = 3'b111;

  // Wide enough for settle counts up to 15 cycles.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    LOAD_OP = 3'd3,
    EXEC    = 3'd4,
    HOLD    = 3'd5
  } state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Collects A, B and opcode bytes from a stream, drives them to the ALU
// result multiplexer, waits a fixed settle time and holds the captured result.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_control,
  input  logic [7:0] alu_result,
  output logic [7:0] res_data,
  output logic       res_zero,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       alu_a_reg, alu_b_reg, res_data_reg;
  logic [2:0]       alu_control_reg;
  logic             res_zero_reg, res_valid_reg;
  logic             xfer, settle_done;

  assign xfer        = in_valid && in_ready;
  assign settle_done = (state_reg == EXEC) && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: state_next = LOAD_A;
      LOAD_A: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LOAD_OP;
      end
      LOAD_OP: begin
        in_ready = 1'b1;
        if (in_valid) state_next = EXEC;
      end
      EXEC: if (settle_done) state_next = HOLD;
      // Release returns to LOAD_A; in_ready only rises the cycle after.
      HOLD: if (res_ready) state_next = LOAD_A;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_control_reg <= '0;
      res_data_reg    <= '0;
      res_zero_reg    <= 1'b0;
      res_valid_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (xfer && state_reg == LOAD_A) alu_a_reg <= in_data;
      if (xfer && state_reg == LOAD_B) alu_b_reg <= in_data;
      if (xfer && state_reg == LOAD_OP) begin
        alu_control_reg <= in_data[2:0];
        cnt_reg         <= '0;
      end
      if (state_reg == EXEC) begin
        if (settle_done) begin
          res_data_reg  <= alu_result;
          res_zero_reg  <= (alu_result == 8'h00);
          res_valid_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      if (state_reg == HOLD && res_ready) res_valid_reg <= 1'b0;
    end
  end

  assign alu_a       = alu_a_reg;
  assign alu_b       = alu_b_reg;
  assign alu_control = alu_control_reg;
  assign res_data    = res_data_reg;
  assign res_zero    = res_zero_reg;
  assign res_valid   = res_valid_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with a 1-cycle settle time
// and one with a 4-cycle settle time, each fed by a behavioural ALU mux.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic       sel = 1'b0;

  logic       in_valid1, in_valid4, res_ready1, res_ready4;
  logic       in_ready1, in_ready4, res_zero1, res_zero4;
  logic       res_valid1, res_valid4, busy1, busy4;
  logic [7:0] alu_a1, alu_a4, alu_b1, alu_b4, res_data1, res_data4;
  logic [7:0] alu_result1, alu_result4;
  logic [2:0] alu_control1, alu_control4;

  logic       in_ready_s, res_zero_s, res_valid_s, busy_s;
  logic [7:0] alu_a_s, alu_b_s, res_data_s;
  logic [2:0] alu_control_s;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] c);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a << 1;
      3'b101:  return a >> 1;
      3'b110:  return b << 1;
      default: return b >> 1;
    endcase
  endfunction

  assign alu_result1 = alu_model(alu_a1, alu_b1, alu_control1);
  assign alu_result4 = alu_model(alu_a4, alu_b4, alu_control4);

  assign in_valid1  = in_valid & ~sel;
  assign in_valid4  = in_valid & sel;
  assign res_ready1 = res_ready & ~sel;
  assign res_ready4 = res_ready & sel;

  assign in_ready_s    = sel ? in_ready4 : in_ready1;
  assign res_zero_s    = sel ? res_zero4 : res_zero1;
  assign res_valid_s   = sel ? res_valid4 : res_valid1;
  assign busy_s        = sel ? busy4 : busy1;
  assign alu_a_s       = sel ? alu_a4 : alu_a1;
  assign alu_b_s       = sel ? alu_b4 : alu_b1;
  assign res_data_s    = sel ? res_data4 : res_data1;
  assign alu_control_s = sel ? alu_control4 : alu_control1;

  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid1),
    .in_ready(in_ready1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_control(alu_control1), .alu_result(alu_result1),
    .res_data(res_data1), .res_zero(res_zero1), .res_valid(res_valid1),
    .res_ready(res_ready1), .busy(busy1)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid4),
    .in_ready(in_ready4), .alu_a(alu_a4), .alu_b(alu_b4),
    .alu_control(alu_control4), .alu_result(alu_result4),
    .res_data(res_data4), .res_zero(res_zero4), .res_valid(res_valid4),
    .res_ready(res_ready4), .busy(busy4)
  );

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_s) check_val("send_timeout", 16'd0, 16'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Sends one command and checks latency and the captured result; leaves it in HOLD.
  task automatic issue_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp_res, input int g0, input int g1, input int g2);
    int cycles = 0;
    int lat;
    lat = sel ? 4 : 1;
    send_byte(a, g0);
    send_byte(b, g1);
    send_byte(op, g2);
    while (!res_valid_s && cycles < 40) begin
      @(posedge clk);
      #1 cycles++;
    end
    check_val("latency", 16'(cycles), 16'(lat));
    check_val("res_data", {8'h00, res_data_s}, {8'h00, exp_res});
    check_val("res_zero", {15'd0, res_zero_s}, {15'd0, exp_res == 8'h00});
    check_val("alu_control", {13'd0, alu_control_s}, {13'd0, op[2:0]});
    check_val("alu_a", {8'h00, alu_a_s}, {8'h00, a});
    check_val("alu_b", {8'h00, alu_b_s}, {8'h00, b});
    $display("cmd dut=%0d a=%02h b=%02h op=%02h res=%02h zero=%0d lat=%0d",
             sel ? 4 : 1, a, b, op, res_data_s, res_zero_s, cycles);
  endtask

  task automatic release_res();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    check_val("rel_valid", {15'd0, res_valid_s}, 16'd0);
    check_val("rel_in_ready", {15'd0, in_ready_s}, 16'd1);
    check_val("rel_busy", {15'd0, busy_s}, 16'd0);
  endtask

  initial begin
    // Reset state
    #3;
    check_val("rst_in_ready", {15'd0, in_ready_s}, 16'd0);
    check_val("rst_busy", {15'd0, busy_s}, 16'd1);
    check_val("rst_res_valid", {15'd0, res_valid_s}, 16'd0);
    check_val("rst_res_data", {8'h00, res_data_s}, 16'd0);
    check_val("rst_alu_a", {8'h00, alu_a_s}, 16'd0);
    repeat (2) @(posedge clk);
    #1 check_val("rst_held_in_ready", {15'd0, in_ready_s}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_val("first_in_ready", {15'd0, in_ready_s}, 16'd1);
    check_val("first_busy", {15'd0, busy_s}, 16'd0);
    $display("reset released");

    // Basic operations on the 1-cycle instance
    issue_cmd(8'h5A, 8'h0F, 8'h00, 8'h69, 0, 0, 0);
    release_res();
    issue_cmd(8'h10, 8'h10, 8'h01, 8'h00, 0, 0, 0);
    release_res();
    issue_cmd(8'h80, 8'h33, 8'hFD, 8'h40, 0, 0, 0);
    release_res();

    // Hold the result while the consumer stalls, with stray input offered
    issue_cmd(8'hC5, 8'h3A, 8'h03, 8'hFF, 0, 0, 0);
    @(negedge clk);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("hold_valid", {15'd0, res_valid_s}, 16'd1);
      check_val("hold_data", {8'h00, res_data_s}, 16'h00FF);
      check_val("hold_busy", {15'd0, busy_s}, 16'd1);
      check_val("hold_in_ready", {15'd0, in_ready_s}, 16'd0);
      check_val("hold_alu", {alu_a_s, alu_b_s}, 16'hC53A);
      check_val("hold_ctrl", {13'd0, alu_control_s}, 16'd3);
    end
    in_valid = 1'b0;
    $display("hold 5 cycles done");
    release_res();

    // Gapped transfers match back-to-back ones
    issue_cmd(8'h21, 8'h3C, 8'h06, 8'h78, 0, 0, 0);
    release_res();
    issue_cmd(8'h21, 8'h3C, 8'h06, 8'h78, 3, 1, 2);
    release_res();
    issue_cmd(8'h12, 8'h9B, 8'hF7, 8'h4D, 2, 0, 3);
    release_res();
    issue_cmd(8'h81, 8'h00, 8'h04, 8'h02, 1, 3, 0);
    release_res();

    // 4-cycle instance: reset in the middle of EXEC
    sel = 1'b1;
    send_byte(8'h44, 0);
    send_byte(8'h11, 0);
    send_byte(8'h00, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("exec_rst_valid", {15'd0, res_valid_s}, 16'd0);
    check_val("exec_rst_data", {8'h00, res_data_s}, 16'd0);
    check_val("exec_rst_alu", {alu_a_s, alu_b_s}, 16'd0);
    check_val("exec_rst_busy", {15'd0, busy_s}, 16'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check_val("exec_rst_no_valid", {15'd0, res_valid_s}, 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset during exec");
    issue_cmd(8'h20, 8'h07, 8'h01, 8'h19, 0, 0, 0);
    release_res();
    issue_cmd(8'hF0, 8'h0F, 8'h02, 8'h00, 1, 2, 1);
    release_res();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "timeout");
  end

endmodule
